// File: rtl/io_pkg.sv
// Shared constants for the I/O page register responder: FSM encodings, register
// indices, the I/O page number and the byte-lane merge helper.
package io_pkg;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StAck  = 2'd2;

    localparam int unsigned NumScratch = 6;
    localparam logic [2:0]  RegCnt     = 3'd6;
    localparam logic [2:0]  RegId      = 3'd7;

    localparam logic [11:0] IoPage = 12'hFD0;

    function automatic logic [31:0] lane_merge(input logic [31:0] base,
                                               input logic [31:0] d,
                                               input logic [3:0]  be);
        logic [31:0] r;
        r = base;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/io_reg_responder_if.sv
// Bridge-to-device bus bundle: request side driven by the bridge master port,
// acknowledge/read-data/tag side driven by the responder.
interface io_reg_responder_if;
    logic        cyc_i;
    logic        stb_i;
    logic        we_i;
    logic [3:0]  sel_i;
    logic [31:0] adr_i;
    logic [31:0] dat_i;
    logic [5:0]  core_i;
    logic        ack_o;
    logic [31:0] dat_o;
    logic [5:0]  core_o;

    modport master (
        output cyc_i, stb_i, we_i, sel_i, adr_i, dat_i, core_i,
        input  ack_o, dat_o, core_o
    );

    modport slave (
        input  cyc_i, stb_i, we_i, sel_i, adr_i, dat_i, core_i,
        output ack_o, dat_o, core_o
    );
endinterface

// File: rtl/io_byte_reg.sv
// 32-bit register with per-byte write enables; unselected lanes load base_i, so
// the same cell serves both hold-style scratch registers and the counter.
module io_byte_reg
    import io_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] base_i,
    input  logic [31:0] d_i,
    output logic [31:0] q_o
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_o <= '0;
        end else begin
            q_o <= lane_merge(base_i, d_i, be_i);
        end
    end

endmodule

// File: rtl/io_reg_responder.sv
// Single 4 KB page I/O responder: six scratch registers, cycle counter and ID word.
// Define IO_RESP_WAIT_EN to add WAIT_STATES wait cycles and the loadable cycle counter.
module io_reg_responder
    import io_pkg::*;
#(
    parameter logic [31:0] IO_BASE     = {IoPage, 20'hA0000},
    parameter logic [31:0] DEV_ID      = 32'h52524731,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    io_reg_responder_if.slave   bus
);

    logic [1:0]  state_q, state_d;
    logic        latch, commit, wait_done;
    logic        cs, active;
    logic        we_q;
    logic [3:0]  sel_q;
    logic [2:0]  idx_q;
    logic [31:0] wdat_q;
    logic [5:0]  core_q;
    logic        ack_q;
    logic [31:0] rdat_q;
    logic [5:0]  rcore_q;
    logic [31:0] rdata;
    logic [31:0] scratch_q [NumScratch];

    assign active = bus.cyc_i & bus.stb_i;
    assign cs     = active & (bus.adr_i[31:12] == IO_BASE[31:12]);

    // Word offsets above the register file alias; byte offset is ignored.
    logic unused_adr;
    assign unused_adr = ^{bus.adr_i[11:5], bus.adr_i[1:0]};

`ifdef IO_RESP_WAIT_EN
    logic [3:0]  wcnt_q, wcnt_d;
    logic [31:0] cnt_q, cnt_inc;
    logic [3:0]  cnt_be;

    assign wait_done = (wcnt_q == 4'd0);

    always_comb begin
        wcnt_d = wcnt_q;
        if (latch) begin
            wcnt_d = 4'(WAIT_STATES);
        end else if (state_q == StWait && !wait_done) begin
            wcnt_d = wcnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) wcnt_q <= '0;
        else       wcnt_q <= wcnt_d;
    end

    assign cnt_inc = cnt_q + 32'd1;
    assign cnt_be  = (commit && we_q && idx_q == RegCnt) ? sel_q : 4'b0000;

    io_byte_reg u_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .be_i   (cnt_be),
        .base_i (cnt_inc),
        .d_i    (wdat_q),
        .q_o    (cnt_q)
    );
`else
    // The decode cycle between latch and ack remains; only the count is gone.
    assign wait_done = 1'b1;
    logic unused_wait;
    assign unused_wait = (WAIT_STATES != 0);
`endif

    for (genvar i = 0; i < NumScratch; i++) begin : g_scratch
        logic [3:0] be;
        assign be = (commit && we_q && idx_q == 3'(i)) ? sel_q : 4'b0000;
        io_byte_reg u_reg (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .be_i   (be),
            .base_i (scratch_q[i]),
            .d_i    (wdat_q),
            .q_o    (scratch_q[i])
        );
    end

    // Read mux sees pre-write contents since registers update on the commit edge.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < NumScratch; i++) begin
            if (idx_q == 3'(i)) rdata = scratch_q[i];
        end
`ifdef IO_RESP_WAIT_EN
        if (idx_q == RegCnt) rdata = cnt_q;
`endif
        if (idx_q == RegId) rdata = DEV_ID;
    end

    always_comb begin
        state_d = state_q;
        latch   = 1'b0;
        commit  = 1'b0;
        case (state_q)
            StIdle: begin
                if (cs) begin
                    latch   = 1'b1;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (!active) begin
                    state_d = StIdle;
                end else if (wait_done) begin
                    commit  = 1'b1;
                    state_d = StAck;
                end
            end
            StAck: begin
                if (!bus.stb_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            sel_q   <= '0;
            idx_q   <= '0;
            wdat_q  <= '0;
            core_q  <= '0;
            ack_q   <= 1'b0;
            rdat_q  <= '0;
            rcore_q <= '0;
        end else begin
            state_q <= state_d;
            if (latch) begin
                we_q   <= bus.we_i;
                sel_q  <= bus.sel_i;
                idx_q  <= bus.adr_i[4:2];
                wdat_q <= bus.dat_i;
                core_q <= bus.core_i;
            end
            if (commit) begin
                ack_q   <= 1'b1;
                rdat_q  <= rdata;
                rcore_q <= core_q;
            end else if (state_q == StAck && !bus.stb_i) begin
                ack_q   <= 1'b0;
                rdat_q  <= '0;
                rcore_q <= '0;
            end
        end
    end

    assign bus.ack_o  = ack_q;
    assign bus.dat_o  = rdat_q;
    assign bus.core_o = rcore_q;

endmodule

// File: tb/tb_io_reg_responder.sv
// Self-checking bench for io_reg_responder: directed scenarios plus randomized
// transactions against a register-file / elapsed-cycle reference model.
module tb_io_reg_responder;

`ifdef IO_RESP_WAIT_EN
    localparam int W = 2;
`else
    localparam int W = 0;
`endif
    localparam logic [31:0] DevId = 32'h52524731;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    longint edge_cnt = 0;
    int     errors = 0;
    int     checks = 0;

    logic [31:0] m_scr [6];
    logic [31:0] m_cnt_base;
    longint      m_cnt_edge;

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    io_reg_responder_if bus ();

    io_reg_responder #(
        .IO_BASE     (32'hFD0A0000),
        .DEV_ID      (DevId),
        .WAIT_STATES (2)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // ---------------- reference model ----------------
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Counter value held just after clock edge e: load value plus edges since load.
    function automatic logic [31:0] m_cnt_after(input longint e);
        return m_cnt_base + 32'(e - m_cnt_edge);
    endfunction

    function automatic logic [31:0] m_read(input int idx, input longint cap);
        if (idx < 6) return m_scr[idx];
        if (idx == 7) return DevId;
`ifdef IO_RESP_WAIT_EN
        return m_cnt_after(cap - 1);
`else
        return (cap < 0) ? 32'hFFFFFFFF : 32'h0;
`endif
    endfunction

    task automatic m_write(input int idx, input logic [3:0] sel, input logic [31:0] d,
                           input longint cap);
        if (idx < 6) begin
            m_scr[idx] = merge(m_scr[idx], d, sel);
        end else if (idx == 6) begin
`ifdef IO_RESP_WAIT_EN
            m_cnt_base = merge(m_cnt_after(cap), d, sel);
            m_cnt_edge = cap;
`endif
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 6; i++) m_scr[i] = '0;
        m_cnt_base = '0;
        m_cnt_edge = edge_cnt;
    endtask

    // ---------------- bus driver ----------------
    task automatic bus_idle();
        bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0; bus.sel_i = '0;
        bus.adr_i = '0; bus.dat_i = '0; bus.core_i = '0;
    endtask

    task automatic bus_xfer(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                            input logic [31:0] dat, input logic [5:0] core,
                            output logic [31:0] rd, output logic [5:0] rc,
                            output int lat, output longint cap);
        @(negedge clk);
        bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = we; bus.sel_i = sel;
        bus.adr_i = adr; bus.dat_i = dat; bus.core_i = core;
        cap = edge_cnt + 2 + W;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (bus.ack_o) break;
        end
        rd = bus.dat_o;
        rc = bus.core_o;
        bus_idle();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus_idle();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        m_reset();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] rd; logic [5:0] rc; int lat; longint cap;
        do_reset();
        checks++; if (bus.ack_o !== 1'b0) begin errors++;
            $display("FAIL reset_ack got=%b exp=0", bus.ack_o); end
        checks++; if (bus.dat_o !== 32'h0) begin errors++;
            $display("FAIL reset_dat got=%h exp=0", bus.dat_o); end
        checks++; if (bus.core_o !== 6'h0) begin errors++;
            $display("FAIL reset_core got=%h exp=0", bus.core_o); end
        bus_xfer(1'b0, 4'hF, 32'hFD0A0000, 32'h0, 6'd1, rd, rc, lat, cap);
        checks++; if (rd !== m_read(0, cap)) begin errors++;
            $display("FAIL reset_scratch0 got=%h exp=%h", rd, m_read(0, cap)); end
        bus_xfer(1'b0, 4'hF, 32'hFD0A0018, 32'h0, 6'd1, rd, rc, lat, cap);
        checks++; if (rd !== m_read(6, cap)) begin errors++;
            $display("FAIL reset_counter got=%h exp=%h", rd, m_read(6, cap)); end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd; logic [5:0] rc; int lat; longint cap;
        bus_xfer(1'b1, 4'b0101, 32'hFD0A0004, 32'hA1B2C3D4, 6'd5, rd, rc, lat, cap);
        m_write(1, 4'b0101, 32'hA1B2C3D4, cap);
        checks++; if (lat !== 2 + W) begin errors++;
            $display("FAIL lane_latency got=%0d exp=%0d", lat, 2 + W); end
        checks++; if (rc !== 6'd5) begin errors++;
            $display("FAIL lane_core_w got=%0d exp=5", rc); end
        checks++; if (bus.ack_o !== 1'b0 || bus.dat_o !== 32'h0) begin errors++;
            $display("FAIL ack_release got ack=%b dat=%h exp 0/0", bus.ack_o, bus.dat_o); end
        bus_xfer(1'b0, 4'hF, 32'hFD0A0004, 32'h0, 6'd5, rd, rc, lat, cap);
        checks++; if (rd !== 32'h00B200D4) begin errors++;
            $display("FAIL lane_read got=%h exp=00b200d4", rd); end
        checks++; if (rc !== 6'd5) begin errors++;
            $display("FAIL lane_core_r got=%0d exp=5", rc); end
    endtask

    task automatic test_dev_id();
        logic [31:0] rd; logic [5:0] rc; int lat; longint cap;
        bus_xfer(1'b0, 4'hF, 32'hFD0A001C, 32'h0, 6'd9, rd, rc, lat, cap);
        checks++; if (rd !== DevId) begin errors++;
            $display("FAIL dev_id got=%h exp=%h", rd, DevId); end
        bus_xfer(1'b1, 4'hF, 32'hFD0A001C, 32'h0, 6'd9, rd, rc, lat, cap);
        bus_xfer(1'b0, 4'hF, 32'hFD0A001C, 32'h0, 6'd9, rd, rc, lat, cap);
        checks++; if (rd !== DevId) begin errors++;
            $display("FAIL dev_id_ro got=%h exp=%h", rd, DevId); end
    endtask

    task automatic test_counter_wrap();
        logic [31:0] rd; logic [5:0] rc; int lat; longint cap;
        bus_xfer(1'b1, 4'hF, 32'hFD0A0018, 32'hFFFFFFFE, 6'd2, rd, rc, lat, cap);
        m_write(6, 4'hF, 32'hFFFFFFFE, cap);
        repeat (3) @(negedge clk);
        bus_xfer(1'b0, 4'hF, 32'hFD0A0018, 32'h0, 6'd2, rd, rc, lat, cap);
        checks++; if (rd !== m_read(6, cap)) begin errors++;
            $display("FAIL counter_wrap got=%h exp=%h", rd, m_read(6, cap)); end
    endtask

`ifdef IO_RESP_WAIT_EN
    task automatic test_wait_abort();
        logic [31:0] rd; logic [5:0] rc; int lat; longint cap; int acks;
        bus_xfer(1'b1, 4'hF, 32'hFD0A0008, 32'h11223344, 6'd3, rd, rc, lat, cap);
        m_write(2, 4'hF, 32'h11223344, cap);
        checks++; if (lat !== 4) begin errors++;
            $display("FAIL wait_latency got=%0d exp=4", lat); end
        @(negedge clk);
        bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b1; bus.sel_i = 4'hF;
        bus.adr_i = 32'hFD0A0008; bus.dat_i = 32'hDEADBEEF; bus.core_i = 6'd3;
        @(negedge clk);
        bus.cyc_i = 1'b0;
        acks = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.ack_o) acks++;
        end
        bus_idle();
        checks++; if (acks !== 0) begin errors++;
            $display("FAIL abort_ack got=%0d acks exp=0", acks); end
        bus_xfer(1'b0, 4'hF, 32'hFD0A0008, 32'h0, 6'd3, rd, rc, lat, cap);
        checks++; if (rd !== m_read(2, cap)) begin errors++;
            $display("FAIL abort_nowrite got=%h exp=%h", rd, m_read(2, cap)); end
    endtask
`endif

    task automatic test_out_of_page();
        int acks;
        @(negedge clk);
        bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b1; bus.sel_i = 4'hF;
        bus.adr_i = 32'hFD0B0000; bus.dat_i = 32'h12345678; bus.core_i = 6'd7;
        acks = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.ack_o || bus.dat_o !== 32'h0) acks++;
        end
        bus_idle();
        checks++; if (acks !== 0) begin errors++;
            $display("FAIL out_of_page got=%0d responses exp=0", acks); end
    endtask

    task automatic test_random();
        logic [31:0] rd, d; logic [5:0] rc, core; logic [3:0] sel; logic we;
        int lat, idx; longint cap;
        for (int n = 0; n < 40; n++) begin
            idx  = $urandom_range(0, 7);
            we   = 1'($urandom);
            sel  = 4'($urandom);
            d    = $urandom;
            core = 6'($urandom);
            bus_xfer(we, sel, {20'hFD0A0, 7'($urandom), 3'(idx), 2'($urandom)}, d, core,
                     rd, rc, lat, cap);
            checks++; if (lat !== 2 + W || rd !== m_read(idx, cap) || rc !== core) begin
                errors++;
                $display("FAIL rand_%0d idx=%0d we=%b got lat=%0d dat=%h core=%0d exp %0d/%h/%0d",
                         n, idx, we, lat, rd, rc, 2 + W, m_read(idx, cap), core);
            end
            if (we) m_write(idx, sel, d, cap);
        end
    endtask

    task automatic test_reset_mid_ack();
        logic [31:0] rd; logic [5:0] rc; int lat; longint cap; int waited;
        @(negedge clk);
        bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b1; bus.sel_i = 4'hF;
        bus.adr_i = 32'hFD0A0004; bus.dat_i = 32'hCAFEF00D; bus.core_i = 6'd33;
        waited = 0;
        while (waited < 20 && !bus.ack_o) begin
            @(negedge clk);
            waited++;
        end
        checks++; if (bus.ack_o !== 1'b1) begin errors++;
            $display("FAIL midack_reach got ack=%b exp=1", bus.ack_o); end
        #1 rst = 1'b1;
        #1;
        checks++; if (bus.ack_o !== 1'b0 || bus.dat_o !== 32'h0 || bus.core_o !== 6'h0) begin
            errors++;
            $display("FAIL midack_clear got ack=%b dat=%h core=%h exp 0/0/0",
                     bus.ack_o, bus.dat_o, bus.core_o);
        end
        bus_idle();
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        bus_xfer(1'b0, 4'hF, 32'hFD0A0004, 32'h0, 6'd1, rd, rc, lat, cap);
        checks++; if (rd !== 32'h0) begin errors++;
            $display("FAIL midack_scratch got=%h exp=0", rd); end
    endtask

    initial begin
        bus_idle();
        test_reset();
        test_byte_lanes();
        test_dev_id();
        test_counter_wrap();
`ifdef IO_RESP_WAIT_EN
        test_wait_abort();
`endif
        test_out_of_page();
        test_random();
        test_reset_mid_ack();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
